// File: rtl/udma_ext_per_rx_packer.sv
// Receive-side byte packer for the external-peripheral uDMA channel.
// Bytes are packed little-endian into 1/2/4-byte words and handed to the uDMA through a one-entry output register.
module udma_ext_per_rx_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cfg_en_i,
  input  logic [1:0]            cfg_datasize_i,
  input  logic                  cfg_clr_i,
  input  logic                  flush_i,
  input  logic [7:0]            in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] data_rx_o,
  output logic [1:0]            data_rx_datasize_o,
  output logic                  data_rx_valid_o,
  input  logic                  data_rx_ready_i,
  output logic [CNT_WIDTH-1:0]  bytes_rcvd_o,
  output logic                  busy_o
);

  // Pack buffer: r_rdy marks a complete (or flushed) word waiting for the output register.
  logic [DATA_WIDTH-1:0] r_buf;
  logic [1:0]            r_idx;
  logic [1:0]            r_ds;
  logic                  r_rdy;

  logic [DATA_WIDTH-1:0] r_out_data;
  logic [1:0]            r_out_ds;
  logic                  r_out_vld;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic                  w_out_free;
  logic                  w_xfer;
  logic                  w_acc;
  logic [1:0]            w_bidx;
  logic [DATA_WIDTH-1:0] w_bbuf;
  logic [1:0]            w_ds_cur;
  logic [DATA_WIDTH-1:0] w_nbuf;
  logic [1:0]            w_nidx;
  logic                  w_done;
  logic                  w_rdy_nxt;

  function automatic logic [1:0] last_idx(input logic [1:0] ds);
    case (ds)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

  always_comb begin
    w_out_free = !r_out_vld || data_rx_ready_i;
    w_xfer     = r_rdy && w_out_free;

    if (cfg_clr_i)
      in_ready_o = 1'b0;
    else if (!cfg_en_i)
      in_ready_o = 1'b1;
    else
      in_ready_o = !(r_rdy && !w_out_free);

    w_acc = in_valid_i && in_ready_o && cfg_en_i;

    // A transferring word vacates the buffer, so a byte this cycle lands at lane 0.
    w_bidx   = w_xfer ? 2'd0 : r_idx;
    w_bbuf   = w_xfer ? '0 : r_buf;
    w_ds_cur = (w_bidx == 2'd0) ? cfg_datasize_i : r_ds;

    w_nbuf = w_bbuf;
    if (w_acc)
      w_nbuf[{w_bidx, 3'b000} +: 8] = in_data_i;

    w_nidx    = w_bidx + {1'b0, w_acc};
    w_done    = w_acc && (w_bidx == last_idx(w_ds_cur));
    w_rdy_nxt = w_done || (flush_i && ((w_bidx != 2'd0) || w_acc));
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_buf      <= '0;
      r_idx      <= 2'd0;
      r_ds       <= 2'd0;
      r_rdy      <= 1'b0;
      r_out_data <= '0;
      r_out_ds   <= 2'd0;
      r_out_vld  <= 1'b0;
      r_cnt      <= '0;
    end else if (cfg_clr_i) begin
      r_buf      <= '0;
      r_idx      <= 2'd0;
      r_ds       <= 2'd0;
      r_rdy      <= 1'b0;
      r_out_data <= '0;
      r_out_ds   <= 2'd0;
      r_out_vld  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_xfer) begin
        r_out_data <= r_buf;
        r_out_ds   <= r_ds;
        r_out_vld  <= 1'b1;
      end else if (data_rx_ready_i) begin
        r_out_vld  <= 1'b0;
      end

      // A stalled complete word holds the buffer untouched.
      if (w_xfer || !r_rdy) begin
        r_buf <= w_nbuf;
        r_idx <= w_nidx;
        r_ds  <= w_ds_cur;
        r_rdy <= w_rdy_nxt;
      end

      if (w_acc)
        r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign data_rx_o          = r_out_data;
  assign data_rx_datasize_o = r_out_ds;
  assign data_rx_valid_o    = r_out_vld;
  assign bytes_rcvd_o       = r_cnt;
  assign busy_o             = r_rdy || (r_idx != 2'd0) || r_out_vld;

endmodule

// File: tb/tb_udma_ext_per_rx_packer.sv
// Bench for udma_ext_per_rx_packer: directed scenarios plus random traffic checked against a queue-based word model.
module tb_udma_ext_per_rx_packer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_en;
  logic [1:0]  cfg_ds;
  logic        cfg_clr;
  logic        flush;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rx_data;
  logic [1:0]  rx_ds;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] bytes_rcvd;
  logic        busy;

  udma_ext_per_rx_packer #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk_i              (clk),
    .rstn_i             (rstn),
    .cfg_en_i           (cfg_en),
    .cfg_datasize_i     (cfg_ds),
    .cfg_clr_i          (cfg_clr),
    .flush_i            (flush),
    .in_data_i          (in_data),
    .in_valid_i         (in_valid),
    .in_ready_o         (in_ready),
    .data_rx_o          (rx_data),
    .data_rx_datasize_o (rx_ds),
    .data_rx_valid_o    (rx_valid),
    .data_rx_ready_i    (rx_ready),
    .bytes_rcvd_o       (bytes_rcvd),
    .busy_o             (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  ds;
  } word_t;

  // Reference model: bytes of the word being assembled, words produced but not yet taken by the uDMA.
  logic [7:0]  cur[$];
  word_t       expq[$];
  logic [1:0]  m_ds;
  bit          m_out_vld;
  logic [15:0] m_cnt;
  bit          m_last_acc;
  int          nwords;
  int          checks;
  int          failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] ds);
    return (ds == 2'b00) ? 1 : ((ds == 2'b01) ? 2 : 4);
  endfunction

  task automatic push_word();
    word_t w;
    w.d  = '0;
    w.ds = m_ds;
    for (int i = 0; i < cur.size(); i++) w.d[8*i +: 8] = cur[i];
    expq.push_back(w);
    cur.delete();
  endtask

  task automatic model_clear();
    cur.delete();
    expq.delete();
    m_out_vld = 1'b0;
    m_cnt     = '0;
  endtask

  // Compare DUT state against the model, then advance the model with this cycle's inputs.
  task automatic monitor();
    bit waiting;
    bit free;
    bit hs;
    bit rdy_exp;
    m_last_acc = 1'b0;
    if (!rstn) begin
      chk("rst_valid", 32'(rx_valid), 32'd0);
      chk("rst_data", rx_data, 32'd0);
      chk("rst_ds", 32'(rx_ds), 32'd0);
      chk("rst_cnt", 32'(bytes_rcvd), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      model_clear();
      return;
    end
    chk("valid", 32'(rx_valid), 32'(m_out_vld));
    if (m_out_vld) begin
      chk("word_data", rx_data, expq[0].d);
      chk("word_ds", 32'(rx_ds), 32'(expq[0].ds));
    end
    chk("busy", 32'(busy), 32'((cur.size() > 0) || (expq.size() > 0)));
    chk("bytes_rcvd", 32'(bytes_rcvd), 32'(m_cnt));
    waiting = (expq.size() > int'(m_out_vld));
    free    = !m_out_vld || rx_ready;
    rdy_exp = cfg_clr ? 1'b0 : (!cfg_en ? 1'b1 : !(waiting && !free));
    chk("in_ready", 32'(in_ready), 32'(rdy_exp));
    if (cfg_clr) begin
      model_clear();
      return;
    end
    hs = m_out_vld && rx_ready;
    if (hs) begin
      void'(expq.pop_front());
      nwords++;
    end
    if (waiting && free) m_out_vld = 1'b1;
    else if (hs)         m_out_vld = 1'b0;
    if (in_valid && rdy_exp && cfg_en) begin
      m_last_acc = 1'b1;
      if (cur.size() == 0) m_ds = cfg_ds;
      cur.push_back(in_data);
      m_cnt++;
      if (cur.size() == nbytes(m_ds)) push_word();
    end
    if (flush && cur.size() > 0) push_word();
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50 && !got; t++) begin
      tick();
      got = m_last_acc;
    end
    in_valid = 1'b0;
    chk("send_accepted", 32'(got), 32'd1);
  endtask

  initial begin
    int n0;
    checks = 0; failures = 0; nwords = 0;
    m_ds = 2'b00; m_last_acc = 1'b0;
    model_clear();
    cfg_en = 1'b1; cfg_ds = 2'b10; cfg_clr = 1'b0; flush = 1'b0;
    in_data = 8'h00; in_valid = 1'b0; rx_ready = 1'b1;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    tick();
    tick();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rstn = 1'b1;
    tick();

    // Word packing with fixed latency
    cfg_ds = 2'b10;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("t1_valid_early", 32'(rx_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(rx_valid), 32'd1);
    chk("t1_data", rx_data, 32'h44332211);
    chk("t1_ds", 32'(rx_ds), 32'd2);
    chk("t1_cnt", 32'(bytes_rcvd), 32'd4);
    tick();

    // Halfword streaming at full rate
    n0 = nwords;
    cfg_ds = 2'b01;
    for (int i = 1; i <= 8; i++) send(8'(i));
    repeat (3) tick();
    chk("t2_words", 32'(nwords), 32'(n0 + 4));

    // Backpressure
    n0 = nwords;
    cfg_ds = 2'b00; rx_ready = 1'b0;
    send(8'hAA); send(8'hBB);
    in_valid = 1'b1; in_data = 8'hCC;
    tick();
    chk("t3_stall", 32'(in_ready), 32'd0);
    chk("t3_hold", rx_data, 32'h000000AA);
    rx_ready = 1'b1;
    send(8'hCC);
    repeat (3) tick();
    chk("t3_words", 32'(nwords), 32'(n0 + 3));

    // Flush of a partial word, then flush of an empty buffer
    cfg_ds = 2'b10;
    send(8'h5A); send(8'h6B);
    flush = 1'b1; tick(); flush = 1'b0; tick();
    chk("t4_valid", 32'(rx_valid), 32'd1);
    chk("t4_data", rx_data, 32'h00006B5A);
    chk("t4_ds", 32'(rx_ds), 32'd2);
    tick();
    flush = 1'b1; tick(); flush = 1'b0; tick(); tick();
    chk("t4_no_word", 32'(rx_valid), 32'd0);
    chk("t4_idle", 32'(busy), 32'd0);

    // Datasize change mid-word
    n0 = nwords;
    cfg_ds = 2'b10;
    send(8'h01);
    cfg_ds = 2'b00;
    send(8'h02); send(8'h03); send(8'h04);
    tick();
    chk("t5_data", rx_data, 32'h04030201);
    chk("t5_ds", 32'(rx_ds), 32'd2);
    send(8'h05); send(8'h06);
    repeat (4) tick();
    chk("t5_words", 32'(nwords), 32'(n0 + 3));

    // Clear while output valid and two bytes buffered
    rx_ready = 1'b0; cfg_ds = 2'b00;
    send(8'h77);
    cfg_ds = 2'b10;
    send(8'h88); send(8'h99);
    chk("t6_pre_valid", 32'(rx_valid), 32'd1);
    cfg_clr = 1'b1; tick(); cfg_clr = 1'b0;
    chk("t6_valid", 32'(rx_valid), 32'd0);
    chk("t6_cnt", 32'(bytes_rcvd), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    rx_ready = 1'b1;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    tick();
    chk("t6_data", rx_data, 32'h04030201);
    tick();

    // Asynchronous reset mid-word
    cfg_ds = 2'b10;
    send(8'hA1); send(8'hA2);
    #2 rstn = 1'b0;
    #1;
    chk("t7_valid", 32'(rx_valid), 32'd0);
    chk("t7_cnt", 32'(bytes_rcvd), 32'd0);
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_data", rx_data, 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    // Counter wrap
    cfg_ds = 2'b00; rx_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in_data = 8'(i);
      tick();
    end
    chk("t8_cnt_max", 32'(bytes_rcvd), 32'h0000FFFF);
    tick();
    chk("t8_cnt_wrap", 32'(bytes_rcvd), 32'd0);
    in_valid = 1'b0;
    repeat (3) tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cfg_en   = ($urandom_range(0, 9) != 0);
      cfg_ds   = 2'($urandom_range(0, 3));
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      rx_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      cfg_clr  = ($urandom_range(0, 199) == 0);
      tick();
    end
    cfg_en = 1'b1; in_valid = 1'b0; rx_ready = 1'b1; cfg_clr = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (5) tick();
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_queue", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/udma_ext_per_rx_packer.md
Name: udma_ext_per_rx_packer

Overview:
- Receive-side data packer for the external peripheral uDMA channel, running on the single uDMA-side clock.
- Accepts a byte stream from the peripheral side (after clock-domain crossing) and assembles little-endian 1/2/4-byte words according to the channel datasize.
- Presents each word on the uDMA RX data channel (data/valid/ready plus datasize), so it forms the receive counterpart of the transmit path that feeds 32-bit words out to the peripheral.

Parameters:
- DATA_WIDTH, 32, output word width; fixed at 32, byte lanes = DATA_WIDTH/8.
- CNT_WIDTH, 16, width of the received-byte status counter.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- cfg_en_i  in  1  channel enable; 0 discards input (in_ready_o=1, bytes dropped, not counted)
- cfg_datasize_i  in  2  00=byte, 01=halfword, 10/11=word
- cfg_clr_i  in  1  synchronous clear of pack buffer, output register and counter
- flush_i  in  1  single-cycle pulse: emit partial word, zero-padded
- in_data_i  in  8  byte from peripheral
- in_valid_i  in  1  byte valid
- in_ready_o  out  1  byte accepted when in_valid_i & in_ready_o
- data_rx_o  out  32  packed word, byte 0 in bits [7:0]
- data_rx_datasize_o  out  2  datasize latched for this word
- data_rx_valid_o  out  1  word valid
- data_rx_ready_i  in  1  uDMA accepts word
- bytes_rcvd_o  out  CNT_WIDTH  bytes accepted since reset/clear, wraps modulo 2^CNT_WIDTH
- busy_o  out  1  pack buffer non-empty or output register valid

Behaviour:
- Reset (async, rstn_i=0): data_rx_o=0, data_rx_valid_o=0, data_rx_datasize_o=0, bytes_rcvd_o=0, busy_o=0, pack count=0, pack buffer=0. in_ready_o is combinational; it is 1 after reset while cfg_en_i=0 or the buffer has room.
- Structure: pack buffer (32 bit plus a 0..3 byte index) feeding a one-entry output register. No bypass; every word takes at least one register stage.
- Target byte count N = 1/2/4 from cfg_datasize_i. N is sampled when the first byte of a word is accepted (index=0) and held until that word is emitted. A datasize change mid-word affects only the next word.
- Byte acceptance (cfg_en_i=1): the byte is written to lane [index], index increments, bytes_rcvd_o increments.
- Word complete: on the cycle the N-th byte is accepted, the full word moves into the output register on the next edge if the register is empty or being drained (data_rx_ready_i=1) that cycle. The pack buffer resets to index 0.
- Latency: last byte accepted at edge k → data_rx_valid_o=1 after edge k+1 → data_rx_valid_o=0 one cycle after the ready handshake, unless a new word is loaded.
- Stall rule: in_ready_o=0 when the pack buffer holds a complete word that could not transfer because the output register is full and not draining. This gives full throughput of 1 byte/cycle when data_rx_ready_i is held at 1.
- Output handshake: data_rx_o and data_rx_datasize_o stay stable while data_rx_valid_o=1 and data_rx_ready_i=0. Valid never drops without ready.
- Unused upper lanes: for byte/halfword words the unused upper lanes are zero.
- flush_i with index>0: the partial word (missing lanes zero) is moved to the output register under the same transfer rule, with datasize equal to the latched N. A byte accepted in the same cycle is included before the flush.
- flush_i with index=0: no effect.
- Pending flush: if a flush cannot transfer, it is held pending, and in_ready_o=0 until it does.
- cfg_clr_i: overrides everything in the same cycle, including a handshake. Output valid, buffer and counter go to 0; in_ready_o=0 for that cycle.
- cfg_en_i deassert mid-word: the buffered partial word and the output register are kept. It resumes packing when re-enabled.
- Counter wrap: bytes_rcvd_o wraps 0xFFFF→0x0000 (CNT_WIDTH=16).

Test Plan:
- Word packing: datasize=10, bytes 0x11,0x22,0x33,0x44 back-to-back, ready=1 → one word 0x44332211, datasize 10, valid one cycle after 4th byte, bytes_rcvd_o=4.
- Halfword streaming at full rate: datasize=01, 8 bytes 0x01..0x08 continuous, ready=1 → words 0x00000201, 0x00000403, 0x00000605, 0x00000807; in_ready_o never 0.
- Backpressure: datasize=00, data_rx_ready_i=0, send 0xAA,0xBB,0xCC → 0xAA held in output, 0xBB in buffer, in_ready_o=0 with 0xCC pending. Raise ready → 0xBB then 0xCC emitted in order, no loss.
- Flush: datasize=10, bytes 0x5A,0x6B then flush_i pulse → word 0x00006B5A, datasize 10. A second flush with empty buffer → no word.
- Datasize change mid-word: datasize=10, send 1 byte, switch to 00, send 3 bytes → one 32-bit word, then subsequent bytes emitted singly.
- Clear and reset: cfg_clr_i while valid=1 and index=2 → valid=0, bytes_rcvd_o=0, next bytes start at lane 0. Async rstn_i mid-word → all outputs 0 immediately. Counter preset via 65535 bytes then 1 more → bytes_rcvd_o=0.
